// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - funct3 encodings for loads and stores
//   - FSM state enumeration
//   - byte-lane width and lane count for the default 32-bit datapath
package lsu_pkg;

  // funct3 encodings; stores reuse B/H/W, only loads have the unsigned forms
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int LANE_W = 8;
  localparam int LANES  = 32 / LANE_W;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RMW_RD = 3'd2,
    S_WR     = 3'd3,
    S_RESP   = 3'd4
  } state_e;

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane helper.
//   funct3    in   access size / signedness
//   lane      in   byte lane of the access (address bits [1:0])
//   rword     in   word read from RAM
//   wdata     in   right-aligned store data
//   ld_data   out  selected byte/halfword/word, sign- or zero-extended
//   st_merged out  rword with the low byte/halfword of wdata inserted at lane
module lsu_align
  import lsu_pkg::*;
#(
  parameter int SIZE = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      lane,
  input  logic [SIZE-1:0] rword,
  input  logic [SIZE-1:0] wdata,
  output logic [SIZE-1:0] ld_data,
  output logic [SIZE-1:0] st_merged
);

  logic [4:0]      shamt;
  logic [SIZE-1:0] shifted;
  logic [SIZE-1:0] lane_mask;

  assign shamt = {lane, 3'b000};

  always_comb begin
    // little-endian: lane k lands in the low bits after shifting right by 8k
    shifted = rword >> shamt;
    ld_data = '0;
    case (funct3)
      F3_B:    ld_data = {{(SIZE-8){shifted[7]}}, shifted[7:0]};
      F3_H:    ld_data = {{(SIZE-16){shifted[15]}}, shifted[15:0]};
      F3_W:    ld_data = shifted;
      F3_BU:   ld_data = {{(SIZE-8){1'b0}}, shifted[7:0]};
      F3_HU:   ld_data = {{(SIZE-16){1'b0}}, shifted[15:0]};
      default: ld_data = '0;
    endcase
  end

  always_comb begin
    lane_mask = '1;
    case (funct3)
      F3_B:    lane_mask = {{(SIZE-8){1'b0}}, 8'hFF} << shamt;
      F3_H:    lane_mask = {{(SIZE-16){1'b0}}, 16'hFFFF} << shamt;
      default: lane_mask = '1;
    endcase
    st_merged = (rword & ~lane_mask) | ((wdata << shamt) & lane_mask);
  end

endmodule

// File: rtl/lsu_rmw.sv
// lsu_rmw: load/store unit performing byte/halfword stores as read-modify-write
// on a word-wide RAM with a combinational read port.
//   clock, reset_n          single clock, synchronous active-low reset
//   req_valid/req_ready     request handshake (ready only in IDLE)
//   req_funct3, req_store   operation select
//   req_addr, req_wdata     byte address, right-aligned store data
//   resp_valid/resp_ready   response handshake
//   resp_rdata, resp_err    load result (0 for stores/errors), error flag
//   ram_address             word index into the RAM
//   ram_data, ram_wren      RAM write word and enable
//   ram_wread, ram_salida   RAM read enable and combinational read word
module lsu_rmw
  import lsu_pkg::*;
#(
  parameter int SIZE      = 32,
  parameter int MEM_DEPTH = 1024
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic            req_store,
  input  logic [SIZE-1:0] req_addr,
  input  logic [SIZE-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [SIZE-1:0] resp_rdata,
  output logic            resp_err,
  output logic [SIZE-1:0] ram_address,
  output logic [SIZE-1:0] ram_data,
  output logic            ram_wren,
  output logic            ram_wread,
  input  logic [SIZE-1:0] ram_salida
);

  localparam logic [SIZE-1:0] DEPTH_LIM = SIZE'(MEM_DEPTH);

  state_e          state_q, state_d;
  logic [2:0]      f3_q, f3_d;
  logic            store_q, store_d;
  logic [SIZE-1:0] addr_q, addr_d;
  logic [SIZE-1:0] wdata_q, wdata_d;
  logic [SIZE-1:0] merged_q, merged_d;
  logic [SIZE-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;

  logic [SIZE-1:0] ld_data;
  logic [SIZE-1:0] st_merged;
  logic            f3_ok, misaligned, out_of_range, req_err;

  lsu_align #(.SIZE(SIZE)) u_align (
    .funct3    (f3_q),
    .lane      (addr_q[1:0]),
    .rword     (ram_salida),
    .wdata     (wdata_q),
    .ld_data   (ld_data),
    .st_merged (st_merged)
  );

  // Request legality, evaluated on the raw request so errors skip the RAM.
  always_comb begin
    if (req_store) f3_ok = req_funct3 inside {F3_B, F3_H, F3_W};
    else           f3_ok = req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    misaligned   = ((req_funct3 == F3_H || req_funct3 == F3_HU) && req_addr[0]) ||
                   (req_funct3 == F3_W && req_addr[1:0] != 2'b00);
    out_of_range = {2'b00, req_addr[SIZE-1:2]} >= DEPTH_LIM;
    req_err      = !f3_ok || misaligned || out_of_range;
  end

  always_comb begin
    state_d  = state_q;
    f3_d     = f3_q;
    store_d  = store_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    merged_d = merged_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          f3_d    = req_funct3;
          store_d = req_store;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          err_d   = req_err;
          rdata_d = '0;
          if (req_err)                 state_d = S_RESP;
          else if (!req_store)         state_d = S_LOAD;
          else if (req_funct3 == F3_W) state_d = S_WR;
          else                         state_d = S_RMW_RD;
        end
      end
      S_LOAD: begin
        rdata_d = ld_data;
        state_d = S_RESP;
      end
      S_RMW_RD: begin
        merged_d = st_merged;
        state_d  = S_WR;
      end
      S_WR: state_d = S_RESP;
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready   = (state_q == S_IDLE);
    resp_valid  = (state_q == S_RESP);
    resp_rdata  = resp_valid ? rdata_q : '0;
    resp_err    = resp_valid & err_q;
    ram_wread   = (state_q == S_LOAD) || (state_q == S_RMW_RD);
    ram_wren    = (state_q == S_WR) && store_q;
    ram_address = (state_q == S_IDLE) ? '0 : {2'b00, addr_q[SIZE-1:2]};
    ram_data    = '0;
    if (state_q == S_WR) ram_data = (f3_q == F3_W) ? wdata_q : merged_q;
  end

  // Control and response flops; reset abandons any in-flight operation.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Operation payload; only ever observed outside IDLE, so no reset needed.
  always_ff @(posedge clock) begin
    f3_q     <= f3_d;
    store_q  <= store_d;
    addr_q   <= addr_d;
    wdata_q  <= wdata_d;
    merged_q <= merged_d;
  end

endmodule

// File: tb/tb_lsu_rmw.sv
module tb_lsu_rmw;
  localparam int SIZE      = 32;
  localparam int MEM_DEPTH = 1024;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [2:0]      req_funct3 = 3'b000;
  logic            req_store = 1'b0;
  logic [SIZE-1:0] req_addr = '0;
  logic [SIZE-1:0] req_wdata = '0;
  logic            resp_valid;
  logic            resp_ready = 1'b0;
  logic [SIZE-1:0] resp_rdata;
  logic            resp_err;
  logic [SIZE-1:0] ram_address;
  logic [SIZE-1:0] ram_data;
  logic            ram_wren;
  logic            ram_wread;
  logic [SIZE-1:0] ram_salida;
  logic            mem_clr = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  lsu_rmw #(.SIZE(SIZE), .MEM_DEPTH(MEM_DEPTH)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_funct3  (req_funct3),
    .req_store   (req_store),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .ram_wren    (ram_wren),
    .ram_wread   (ram_wread),
    .ram_salida  (ram_salida)
  );

  // Attached RAM: combinational read, synchronous write
  logic [31:0] mem [0:MEM_DEPTH-1];
  always_comb ram_salida = (ram_address < MEM_DEPTH) ? mem[ram_address[9:0]] : '0;
  always @(posedge clock) begin
    if (mem_clr) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (ram_wren && ram_address < MEM_DEPTH) begin
      mem[ram_address[9:0]] <= ram_data;
    end
  end

  // Reference model memory, byte addressed
  logic [7:0] ref_bytes [0:4*MEM_DEPTH-1];

  function automatic logic [31:0] ref_word(input int idx);
    return {ref_bytes[4*idx+3], ref_bytes[4*idx+2], ref_bytes[4*idx+1], ref_bytes[4*idx]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Behavioural model: access size from funct3, bytes from a byte array
  task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output logic err, output logic [31:0] rd,
                       output int lat, output int nwr, output int nrd, output logic [31:0] wword);
    int size;
    logic legal;
    logic [31:0] v;
    legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    err   = !legal || (addr % size != 0) || ((addr >> 2) >= MEM_DEPTH);
    rd = '0; wword = '0; nwr = 0; nrd = 0; lat = 1;
    if (err) return;
    if (!st) begin
      v = '0;
      for (int i = 0; i < size; i++) v = v | (32'(ref_bytes[int'(addr[11:0]) + i]) << (8 * i));
      if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
      rd = v; lat = 2; nrd = 1;
    end else begin
      for (int i = 0; i < size; i++) ref_bytes[int'(addr[11:0]) + i] = wd[8*i +: 8];
      wword = ref_word(int'(addr >> 2));
      nwr = 1;
      nrd = (size < 4) ? 1 : 0;
      lat = (size < 4) ? 3 : 2;
    end
  endtask

  // Issue one request, observe RAM activity and the response, then hand it off.
  task automatic run_op(input string nm, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input int hold,
                        input logic e_err, input logic [31:0] e_rd, input int e_lat,
                        input int e_nwr, input int e_nrd, input logic [31:0] e_wword);
    int w, lat, nwr, nrd, nboth;
    logic [31:0] wword, waddr, rd0;
    logic err0;
    w = 0;
    while (!req_ready && w < 10) begin @(posedge clock); #1; w++; end
    chk({nm, "_req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clock); #1;
    req_valid = 1'b0;
    lat = 1; nwr = 0; nrd = 0; nboth = 0; wword = '0; waddr = '0;
    while (!resp_valid && lat < 12) begin
      if (ram_wren) begin nwr++; wword = ram_data; waddr = ram_address; end
      if (ram_wread) nrd++;
      if (ram_wren && ram_wread) nboth++;
      @(posedge clock); #1;
      lat++;
    end
    chk({nm, "_latency"}, 32'(lat), 32'(e_lat));
    chk({nm, "_err"}, 32'(resp_err), 32'(e_err));
    chk({nm, "_rdata"}, resp_rdata, e_rd);
    chk({nm, "_wren_cycles"}, 32'(nwr), 32'(e_nwr));
    chk({nm, "_wread_cycles"}, 32'(nrd), 32'(e_nrd));
    chk({nm, "_wren_and_wread"}, 32'(nboth), 32'd0);
    if (e_nwr != 0) begin
      chk({nm, "_ram_data"}, wword, e_wword);
      chk({nm, "_ram_address"}, waddr, addr >> 2);
    end
    err0 = resp_err; rd0 = resp_rdata;
    for (int h = 0; h < hold; h++) begin
      @(posedge clock); #1;
      chk({nm, "_hold_valid"}, 32'(resp_valid), 32'd1);
      chk({nm, "_hold_rdata"}, resp_rdata, rd0);
      chk({nm, "_hold_err"}, 32'(resp_err), 32'(err0));
      chk({nm, "_hold_req_ready"}, 32'(req_ready), 32'd0);
      chk({nm, "_hold_ram_en"}, 32'(ram_wren | ram_wread), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
    chk({nm, "_after_valid"}, 32'(resp_valid), 32'd0);
    chk({nm, "_after_req_ready"}, 32'(req_ready), 32'd1);
  endtask

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    int          hold;
    logic        err;
    logic [31:0] rd;
    int          lat;
    logic [31:0] wword;
  } vec_t;

  initial begin
    vec_t tbl[$];
    logic        m_err;
    logic [31:0] m_rd, m_ww, a, wd;
    int          m_lat, m_nwr, m_nrd, e_nwr, e_nrd, sel;
    logic        st;
    logic [2:0]  f3;

    for (int i = 0; i < 4 * MEM_DEPTH; i++) ref_bytes[i] = 8'h00;

    //            st    f3      addr          wdata         hold err rdata         lat ram_data
    tbl.push_back('{1'b1, 3'b010, 32'h0000_0008, 32'hDEAD_BEEF, 0, 1'b0, 32'h0000_0000, 2, 32'hDEAD_BEEF});
    tbl.push_back('{1'b0, 3'b000, 32'h0000_000B, 32'h0,         5, 1'b0, 32'hFFFF_FFDE, 2, 32'h0});
    tbl.push_back('{1'b0, 3'b100, 32'h0000_000B, 32'h0,         0, 1'b0, 32'h0000_00DE, 2, 32'h0});
    tbl.push_back('{1'b0, 3'b001, 32'h0000_000A, 32'h0,         0, 1'b0, 32'hFFFF_DEAD, 2, 32'h0});
    tbl.push_back('{1'b0, 3'b101, 32'h0000_000A, 32'h0,         0, 1'b0, 32'h0000_DEAD, 2, 32'h0});
    tbl.push_back('{1'b1, 3'b000, 32'h0000_0009, 32'h0000_0012, 0, 1'b0, 32'h0000_0000, 3, 32'hDEAD_12EF});
    tbl.push_back('{1'b0, 3'b010, 32'h0000_0008, 32'h0,         0, 1'b0, 32'hDEAD_12EF, 2, 32'h0});
    tbl.push_back('{1'b1, 3'b001, 32'h0000_000A, 32'h5555_CAFE, 0, 1'b0, 32'h0000_0000, 3, 32'hCAFE_12EF});
    tbl.push_back('{1'b0, 3'b010, 32'h0000_0008, 32'h0,         0, 1'b0, 32'hCAFE_12EF, 2, 32'h0});
    tbl.push_back('{1'b0, 3'b010, 32'h0000_0006, 32'h0,         0, 1'b1, 32'h0000_0000, 1, 32'h0});
    tbl.push_back('{1'b0, 3'b010, 32'h0000_1000, 32'h0,         0, 1'b1, 32'h0000_0000, 1, 32'h0});
    tbl.push_back('{1'b0, 3'b001, 32'h0000_0009, 32'h0,         0, 1'b1, 32'h0000_0000, 1, 32'h0});
    tbl.push_back('{1'b0, 3'b011, 32'h0000_0008, 32'h0,         0, 1'b1, 32'h0000_0000, 1, 32'h0});
    tbl.push_back('{1'b1, 3'b100, 32'h0000_0008, 32'h1111_1111, 0, 1'b1, 32'h0000_0000, 1, 32'h0});
    tbl.push_back('{1'b1, 3'b010, 32'h0000_1000, 32'h1111_1111, 0, 1'b1, 32'h0000_0000, 1, 32'h0});
    tbl.push_back('{1'b1, 3'b010, 32'h0000_0FFC, 32'h0BAD_F00D, 0, 1'b0, 32'h0000_0000, 2, 32'h0BAD_F00D});
    tbl.push_back('{1'b0, 3'b010, 32'h0000_0FFC, 32'h0,         0, 1'b0, 32'h0BAD_F00D, 2, 32'h0});

    // Reset: memory cleared, DUT idle with all outputs low
    repeat (3) @(posedge clock);
    #1;
    mem_clr = 1'b0;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_ram_wren", 32'(ram_wren), 32'd0);
    chk("rst_ram_wread", 32'(ram_wread), 32'd0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Directed vectors
    for (int i = 0; i < tbl.size(); i++) begin
      model(tbl[i].st, tbl[i].f3, tbl[i].addr, tbl[i].wd, m_err, m_rd, m_lat, m_nwr, m_nrd, m_ww);
      e_nwr = (tbl[i].st && !tbl[i].err) ? 1 : 0;
      e_nrd = (!tbl[i].err && (!tbl[i].st || tbl[i].f3 != 3'b010)) ? 1 : 0;
      run_op($sformatf("vec%0d", i), tbl[i].st, tbl[i].f3, tbl[i].addr, tbl[i].wd, tbl[i].hold,
             tbl[i].err, tbl[i].rd, tbl[i].lat, e_nwr, e_nrd, tbl[i].wword);
    end

    // Reset while an SH sits in its read phase: write must never happen
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b001;
    req_addr = 32'h0000_0012; req_wdata = 32'h0000_7777;
    @(posedge clock); #1;
    req_valid = 1'b0;
    chk("rmwrst_in_read", 32'(ram_wread), 32'd1);
    reset_n = 1'b0;
    @(posedge clock); #1;
    chk("rmwrst_wren", 32'(ram_wren), 32'd0);
    chk("rmwrst_wread", 32'(ram_wread), 32'd0);
    chk("rmwrst_req_ready", 32'(req_ready), 32'd1);
    chk("rmwrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rmwrst_resp_err", 32'(resp_err), 32'd0);
    chk("rmwrst_resp_rdata", resp_rdata, 32'd0);
    chk("rmwrst_ram_address", ram_address, 32'd0);
    chk("rmwrst_ram_data", ram_data, 32'd0);
    reset_n = 1'b1;
    @(posedge clock); #1;
    chk("rmwrst_wren_after", 32'(ram_wren), 32'd0);
    chk("rmwrst_mem_word4", mem[4], ref_word(4));

    // Randomized operations against the model
    for (int n = 0; n < 300; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 8)       a = 32'($urandom_range(0, 63));
      else if (sel == 8) a = 32'($urandom_range(4088, 4103));
      else               a = $urandom;
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      wd = $urandom;
      model(st, f3, a, wd, m_err, m_rd, m_lat, m_nwr, m_nrd, m_ww);
      run_op($sformatf("rnd%0d", n), st, f3, a, wd, int'($urandom_range(0, 2)),
             m_err, m_rd, m_lat, m_nwr, m_nrd, m_ww);
    end

    // Final memory image
    for (int i = 0; i < 16; i++) chk($sformatf("mem%0d", i), mem[i], ref_word(i));
    chk("mem1023", mem[1023], ref_word(1023));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_rmw.md
LSU_RMW -- requirements
Module: lsu_rmw

Interface
REQ-001 Parameter SIZE, default 32: data and address width in bits.
REQ-002 Parameter MEM_DEPTH, default 1024: number of SIZE-bit words in the attached data RAM.
REQ-003 clock  in  1  single clock for the whole block; all state changes on its rising edge.
REQ-004 reset_n  in  1  reset, synchronous and active-low.
REQ-005 req_valid  in  1  core presents a memory operation this cycle.
REQ-006 req_ready  out  1  block accepts a request this cycle.
REQ-007 req_funct3  in  3  operation: LB=000, LH=001, LW=010, LBU=100, LHU=101, SB=000, SH=001, SW=010.
REQ-008 req_store  in  1  1 = store, 0 = load; qualifies req_funct3.
REQ-009 req_addr  in  SIZE  byte address from the ALU result.
REQ-010 req_wdata  in  SIZE  store data, right-aligned.
REQ-011 resp_valid  out  1  response available.
REQ-012 resp_ready  in  1  core consumes the response.
REQ-013 resp_rdata  out  SIZE  load result, sign- or zero-extended; 0 for stores and errors.
REQ-014 resp_err  out  1  misaligned, out-of-range or illegal-funct3 access.
REQ-015 ram_address  out  SIZE  word index to the RAM: req_addr[SIZE-1:2], zero-extended.
REQ-016 ram_data  out  SIZE  RAM write word.
REQ-017 ram_wren  out  1  RAM write enable.
REQ-018 ram_wread  out  1  RAM read enable.
REQ-019 ram_salida  in  SIZE  RAM combinational read word.

Function
REQ-020 FSM states: IDLE, LOAD, RMW_RD, WR, RESP.
REQ-021 IDLE: req_ready=1; the request is accepted when req_valid=1; the block latches funct3, store, addr and wdata on acceptance.
REQ-022 On acceptance, an error goes straight to RESP with resp_err=1 and no RAM access. Errors are:
  - halfword address with addr[0]=1;
  - word address with addr[1:0]!=0;
  - word index >= MEM_DEPTH;
  - funct3 not listed in REQ-007.
REQ-023 On acceptance, a legal access moves to the next state:
  - load -> LOAD;
  - SW -> WR;
  - SB or SH -> RMW_RD.
REQ-024 LOAD: ram_wread=1; extract the byte/halfword selected by addr[1:0], extend it per funct3 into resp_rdata; -> RESP.
REQ-025 RMW_RD: ram_wread=1; merge the low byte/halfword of wdata into ram_salida at lane addr[1:0] and register the merged word; -> WR.
REQ-026 WR: ram_wren=1; ram_data = merged word (SB/SH) or wdata (SW); -> RESP.
REQ-027 RESP: resp_valid=1 with resp_rdata and resp_err stable; on resp_ready=1 -> IDLE; otherwise hold indefinitely.
REQ-028 ram_wren and ram_wread are never both 1; both are 0 in IDLE and RESP.
REQ-029 Latency from the acceptance cycle N to first resp_valid:
  - error: N+1;
  - LW/LH/LB/LHU/LBU: N+2;
  - SW: N+2;
  - SB/SH: N+3.
REQ-030 A new request is never accepted in the same cycle as resp_valid&resp_ready; the earliest next acceptance is the following cycle (IDLE).
REQ-031 ram_address is driven from the latched address in every non-IDLE state.
REQ-032 The byte-lane mapping is little-endian: lane k = bits [8k+7:8k].

Reset
REQ-033 While reset_n=0 at a clock edge:
  - state <- IDLE;
  - resp_valid, resp_err, resp_rdata, ram_wren and ram_wread <- 0;
  - any in-flight operation is abandoned.
REQ-034 Reset asserted during WR suppresses the write from the next edge onward; the already-sampled write edge is not undone.

Structure
REQ-035 A shared package lsu_pkg holds:
  - the funct3 encodings as named constants;
  - the FSM state enum;
  - a localparam for the lane count (SIZE/8).
REQ-036 One combinational sub-module, lsu_align, performs lane extraction with sign/zero extension and lane merging.

Verification
REQ-037 Bench scenarios, each stimulus -> required response:
  - Reset, then SW addr=0x8 wdata=0xDEADBEEF -> ram_wren=1 one cycle with ram_address=2, ram_data=0xDEADBEEF; resp at N+2 with err=0.
  - Word 2 = 0xDEADBEEF, LB addr=0xB -> resp_rdata=0xFFFFFFDE; LBU addr=0xB -> 0x000000DE; LH addr=0xA -> 0xFFFFDEAD.
  - SB addr=0x9 wdata=0x12 over word 0xDEADBEEF -> one RMW_RD cycle, then WR with ram_data=0xDEAD12EF; resp at N+3.
  - LW addr=0x6 -> resp_err=1, rdata=0, ram_wren and ram_wread never asserted, resp at N+1; LW addr=0x1000 (index 1024) -> same.
  - resp_ready held 0 for 5 cycles during a load -> resp_valid and resp_rdata stable, req_ready=0; resp_ready=1 -> IDLE next cycle.
  - reset_n=0 while in RMW_RD of an SH -> no ram_wren pulse; IDLE and all outputs 0 after the edge.
